// File: rtl/ram_pkg.sv
//------------------------------------------------------------------------------
// Module  : ram_pkg
// Purpose : Shared types and helpers for the parametrised dual-port
//           distributed RAM: sweep FSM state type and the INIT word locator.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_pkg;

  // Two-state controller: normal operation or INIT-restore sweep.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // LSB position of word idx inside a flattened INIT vector of
  // width-bit words (word i lives at INIT[i*width +: width]).
  function automatic int init_word_lsb(input int width, input int idx);
    return width * idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dp_core.sv
//------------------------------------------------------------------------------
// Module  : ram_dp_core
// Purpose : Plain WIDTH x DEPTH storage array, one synchronous write port and
//           two asynchronous read ports. No reset: contents are restored by
//           the sweep logic in the parent.
// Ports   : clk_i                       write clock
//           we_i, waddr_i, wdata_i      write port
//           raddr_a_i / rdata_a_o       async read port A
//           raddr_b_i / rdata_b_o       async read port B
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_dp_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/ram_dp_dist_param.sv
//------------------------------------------------------------------------------
// Module  : ram_dp_dist_param
// Purpose : Parametrised dual-port distributed RAM with optional output
//           registers, INIT-restore sweep (after reset and on CLR request)
//           and write/read collision flag.
// Ports   : WCLK   clock              RST_N  async active-low reset
//           WE/A/D write port (A also addresses SPO)
//           DPRA   DPO read address   CLR    sweep request (sampled in IDLE)
//           SPO    data at A          DPO    data at DPRA
//           BUSY   sweep in progress  WCOLL  last accepted write had A==DPRA
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_dp_dist_param
  import ram_pkg::*;
#(
  parameter int                     WIDTH     = 8,
  parameter int                     DEPTH     = 64,
  parameter int                     AW        = $clog2(DEPTH),
  parameter logic [WIDTH*DEPTH-1:0] INIT      = '0,
  parameter int                     OREG      = 0,
  parameter int                     SWEEP_RST = 1
) (
  input  logic             WCLK,
  input  logic             RST_N,
  input  logic             WE,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    DPRA,
  input  logic             CLR,
  output logic [WIDTH-1:0] SPO,
  output logic [WIDTH-1:0] DPO,
  output logic             BUSY,
  output logic             WCOLL
);

  localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
  localparam sweep_state_e  c_RST_STATE = (SWEEP_RST != 0) ? SWEEP : IDLE;

  sweep_state_e     state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wcoll_q, wcoll_d;

  logic             w_busy;
  logic             w_core_we;
  logic [AW-1:0]    w_core_addr;
  logic [WIDTH-1:0] w_core_data;
  logic [WIDTH-1:0] w_init_word;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_busy = (state_q == SWEEP);

  //--------------------------------------------------------------------------
  // Sweep controller
  //--------------------------------------------------------------------------
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= c_RST_STATE;
      cnt_q   <= '0;
      wcoll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcoll_q <= wcoll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    wcoll_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
        end
        wcoll_d = WE && (A == DPRA);
      end
      SWEEP: begin
        // One word restored per cycle; CLR is not looked at here, so a
        // request during the sweep neither restarts nor extends it.
        if (cnt_q == c_LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Write mux: sweep owns the write port while BUSY. Writes are gated by
  // RST_N so the array is left untouched while reset is held.
  //--------------------------------------------------------------------------
  assign w_init_word = INIT[init_word_lsb(WIDTH, int'(cnt_q)) +: WIDTH];
  assign w_core_we   = RST_N && (w_busy || WE);
  assign w_core_addr = w_busy ? cnt_q       : A;
  assign w_core_data = w_busy ? w_init_word : D;

  ram_dp_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk_i     (WCLK),
    .we_i      (w_core_we),
    .waddr_i   (w_core_addr),
    .wdata_i   (w_core_data),
    .raddr_a_i (A),
    .raddr_b_i (DPRA),
    .rdata_a_o (w_rd_a),
    .rdata_b_o (w_rd_b)
  );

  //--------------------------------------------------------------------------
  // Read outputs. The registered variant samples the array before the
  // same-edge write lands, giving read-first behaviour.
  //--------------------------------------------------------------------------
  if (OREG != 0) begin : g_oreg
    logic [WIDTH-1:0] spo_q;
    logic [WIDTH-1:0] dpo_q;

    always_ff @(posedge WCLK or negedge RST_N) begin
      if (!RST_N) begin
        spo_q <= '0;
        dpo_q <= '0;
      end else begin
        spo_q <= w_rd_a;
        dpo_q <= w_rd_b;
      end
    end

    assign SPO = spo_q;
    assign DPO = dpo_q;
  end else begin : g_async
    assign SPO = w_rd_a;
    assign DPO = w_rd_b;
  end

  assign BUSY  = w_busy;
  assign WCOLL = wcoll_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_dist_param.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_dp_dist_param
// Purpose : Self-checking bench for ram_dp_dist_param (WIDTH=8, DEPTH=16,
//           INIT word i = 8'hA0+i), asynchronous-read and registered-read
//           instances driven in parallel against an array reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_dp_dist_param;

  localparam int            c_W     = 8;
  localparam int            c_DEPTH = 16;
  localparam int            c_AW    = 4;
  localparam logic [127:0]  c_INIT  = {8'hAF, 8'hAE, 8'hAD, 8'hAC, 8'hAB, 8'hAA, 8'hA9, 8'hA8,
                                       8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

  logic            clk = 1'b0;
  logic            RST_N = 1'b0;
  logic            WE = 1'b0;
  logic [c_AW-1:0] A = '0;
  logic [c_W-1:0]  D = '0;
  logic [c_AW-1:0] DPRA = '0;
  logic            CLR = 1'b0;

  logic [c_W-1:0]  spo0, dpo0, spo1, dpo1;
  logic            busy0, busy1, wcoll0, wcoll1;

  always #5 clk = ~clk;

  ram_dp_dist_param #(.WIDTH(c_W), .DEPTH(c_DEPTH), .INIT(c_INIT), .OREG(0), .SWEEP_RST(1)) u_dut0 (
    .WCLK(clk), .RST_N(RST_N), .WE(WE), .A(A), .D(D), .DPRA(DPRA), .CLR(CLR),
    .SPO(spo0), .DPO(dpo0), .BUSY(busy0), .WCOLL(wcoll0));

  ram_dp_dist_param #(.WIDTH(c_W), .DEPTH(c_DEPTH), .INIT(c_INIT), .OREG(1), .SWEEP_RST(1)) u_dut1 (
    .WCLK(clk), .RST_N(RST_N), .WE(WE), .A(A), .D(D), .DPRA(DPRA), .CLR(CLR),
    .SPO(spo1), .DPO(dpo1), .BUSY(busy1), .WCOLL(wcoll1));

  // Reference model: memory image with a "known" flag per word, sweep as a
  // simple remaining-word walk, registered read values as captured copies.
  logic [7:0] m_mem   [c_DEPTH];
  bit         m_known [c_DEPTH];
  bit         m_busy  = 1'b1;
  int         m_idx   = 0;
  bit         m_coll  = 1'b0;
  logic [7:0] m_spo1  = '0;
  logic [7:0] m_dpo1  = '0;
  bit         m_kspo1 = 1'b1;
  bit         m_kdpo1 = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("busy0", 32'(busy0), 32'(m_busy));
    chk("busy1", 32'(busy1), 32'(m_busy));
    chk("wcoll0", 32'(wcoll0), 32'(m_coll));
    chk("wcoll1", 32'(wcoll1), 32'(m_coll));
    if (m_known[A])    chk("spo_async", 32'(spo0), 32'(m_mem[A]));
    if (m_known[DPRA]) chk("dpo_async", 32'(dpo0), 32'(m_mem[DPRA]));
    if (m_kspo1)       chk("spo_reg", 32'(spo1), 32'(m_spo1));
    if (m_kdpo1)       chk("dpo_reg", 32'(dpo1), 32'(m_dpo1));
  endtask

  // One clock cycle: drive at negedge, model the rising edge, check 1ns later.
  task automatic cyc(input logic rstn, input logic we, input logic [3:0] a,
                     input logic [7:0] d, input logic [3:0] dpra, input logic clr);
    @(negedge clk);
    WE = we; A = a; D = d; DPRA = dpra; CLR = clr;
    if (!rstn && RST_N) begin
      RST_N   = 1'b0;
      m_busy  = 1'b1;
      m_idx   = 0;
      m_coll  = 1'b0;
      m_spo1  = '0;  m_dpo1 = '0;
      m_kspo1 = 1'b1; m_kdpo1 = 1'b1;
      #1;
      check_outputs();
    end
    RST_N = rstn;
    @(posedge clk);
    if (RST_N) begin
      m_spo1  = m_mem[a];    m_kspo1 = m_known[a];
      m_dpo1  = m_mem[dpra]; m_kdpo1 = m_known[dpra];
      m_coll  = 1'b0;
      if (m_busy) begin
        m_mem[m_idx]   = 8'(8'hA0 + m_idx);
        m_known[m_idx] = 1'b1;
        m_idx++;
        if (m_idx == c_DEPTH) begin
          m_busy = 1'b0;
          m_idx  = 0;
        end
      end else begin
        if (we) begin
          m_mem[a]   = d;
          m_known[a] = 1'b1;
        end
        m_coll = we && (a == dpra);
        if (clr) m_busy = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_cyc(input logic [3:0] a, input logic [3:0] dpra);
    cyc(1'b1, 1'b0, a, 8'h00, dpra, 1'b0);
  endtask

  // Runs cycles while BUSY is high (bounded), optional CLR pulse at step
  // clr_at, random writes that must be ignored; returns cycles counted.
  task automatic run_sweep(input int clr_at, output int n);
    n = 0;
    while (busy0 && n < 100) begin
      cyc(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 1'(n == clr_at));
      n++;
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < c_DEPTH; i++) m_known[i] = 1'b0;

    // 1: reset, then post-reset sweep lasting exactly 16 cycles
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    #1 check_outputs();
    cyc(1'b0, 1'b1, 4'd1, 8'h12, 4'd1, 1'b1);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    n = 1;
    run_sweep(-1, n);
    n = n + 1;
    chk("t1_busy_cycles", 32'(n), 32'd16);
    idle_cyc(4'd0, 4'd5);
    chk("t1_dpo5", 32'(dpo0), 32'h0000_00A5);

    // 2: async read sees write right after the edge, WCOLL pulses once
    cyc(1'b1, 1'b1, 4'd3, 8'h5C, 4'd3, 1'b0);
    chk("t2_dpo3", 32'(dpo0), 32'h0000_005C);
    chk("t2_wcoll", 32'(wcoll0), 32'd1);
    idle_cyc(4'd3, 4'd3);
    chk("t2_wcoll_drop", 32'(wcoll0), 32'd0);

    // 3: registered read is read-first
    cyc(1'b1, 1'b1, 4'd7, 8'h11, 4'd7, 1'b0);
    chk("t3_old", 32'(spo1), 32'h0000_00A7);
    idle_cyc(4'd7, 4'd7);
    chk("t3_new", 32'(spo1), 32'h0000_0011);

    // 4: write during sweep ignored
    cyc(1'b1, 1'b1, 4'd2, 8'h77, 4'd0, 1'b1);
    cyc(1'b1, 1'b1, 4'd2, 8'hFF, 4'd2, 1'b0);
    chk("t4_wcoll_busy", 32'(wcoll0), 32'd0);
    run_sweep(-1, n);
    idle_cyc(4'd2, 4'd2);
    chk("t4_spo2", 32'(spo0), 32'h0000_00A2);

    // 5: fill with ~i, CLR sweep restores INIT; CLR mid-sweep does not restart
    for (int i = 0; i < c_DEPTH; i++) cyc(1'b1, 1'b1, 4'(i), ~8'(i), 4'(i), 1'b0);
    idle_cyc(4'd9, 4'd9);
    chk("t5_fill9", 32'(spo0), 32'h0000_00F6);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 1'b1);
    run_sweep(8, n);
    chk("t5_busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < c_DEPTH; i++) begin
      idle_cyc(4'(15 - i), 4'(i));
      chk("t5_restore", 32'(dpo0), 32'(8'hA0 + 8'(i)));
    end

    // 6: reset at sweep count 9, full sweep on release
    cyc(1'b1, 1'b1, 4'd4, 8'h44, 4'd4, 1'b1);
    for (int i = 0; i < 9; i++) idle_cyc(4'(i), 4'(i));
    cyc(1'b0, 1'b1, 4'd5, 8'h55, 4'd5, 1'b0);
    chk("t6_busy", 32'(busy0), 32'd1);
    chk("t6_wcoll", 32'(wcoll0), 32'd0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
    run_sweep(-1, n);
    chk("t6_busy_cycles", 32'(n + 1), 32'd16);

    // Random traffic with occasional sweep requests
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom),
          1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
